// File: rtl/reg_file_pkg.sv
// Shared constants for the RV32I integer register file and its read ports.
package reg_file_pkg;

  localparam int REG_DATA_W   = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;

  localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: reset, enable and x0 force zero; an in-flight
// write to the same index bypasses the array.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = ZERO_WORD;
    if (rst) begin
      rdata = ZERO_WORD;
    end else if (re == READ_DISABLE) begin
      rdata = ZERO_WORD;
    end else if (raddr == NOP_REG_ADDR) begin
      rdata = ZERO_WORD;
    end else if ((we == WRITE_ENABLE) && (waddr == raddr)) begin
      // Same-cycle bypass keeps ID free of a WB forwarding path.
      rdata = wdata;
    end else begin
      rdata = rword;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file x0..x31: one WB write port, two ID read ports with
// same-cycle write-to-read bypass. x0 always reads as zero.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if ((we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = ZERO_WORD;
  end

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= ZERO_WORD;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
    .rst   (rst),
    .re    (re1),
    .raddr (raddr1),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .rword (regs_q[raddr1]),
    .rdata (rdata1)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
    .rst   (rst),
    .re    (re2),
    .raddr (raddr2),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .rword (regs_q[raddr2]),
    .rdata (rdata2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, then random traffic
// against an array-based reference model.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  reg_file dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  function automatic logic [31:0] model_read(input logic r, input logic w,
      input logic [4:0] wa, input logic [31:0] wd, input logic re,
      input logic [4:0] ra);
    if (r || !re || ra == 5'd0) return 32'h0;
    if (w && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic w, input logic [4:0] wa,
      input logic [31:0] wd, input logic e1, input logic [4:0] a1,
      input logic e2, input logic [4:0] a2, input logic [31:0] x1,
      input logic [31:0] x2, input string nm);
    vec_t v;
    v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd;
    v.re1 = e1; v.raddr1 = a1; v.re2 = e2; v.raddr2 = a2;
    v.exp1 = x1; v.exp2 = x2; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one cycle, check the combinational outputs before the edge, then
  // advance the reference model at the edge.
  task automatic run_cycle(input logic r, input logic w, input logic [4:0] wa,
      input logic [31:0] wd, input logic e1, input logic [4:0] a1,
      input logic e2, input logic [4:0] a2, input logic [31:0] x1,
      input logic [31:0] x2, input string nm, input bit do_check);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
    if (do_check) begin
      check({nm, ".rdata1"}, rdata1, x1);
      check({nm, ".rdata2"}, rdata2, x2);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset and reset-clear
    add_vec(1, 1, 5, 32'h00001234, 1, 5, 1, 5, 32'h0, 32'h0, "rst_initial");
    add_vec(0, 1, 5, 32'hDEADBEEF, 0, 5, 0, 5, 32'h0, 32'h0, "wr_x5");
    add_vec(0, 0, 0, 32'h0, 1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, "rd_x5");
    add_vec(1, 1, 5, 32'h00001234, 1, 5, 1, 5, 32'h0, 32'h0, "rst_with_wr");
    add_vec(0, 0, 0, 32'h0, 1, 5, 1, 5, 32'h0, 32'h0, "x5_after_rst");
    // Basic write/read
    add_vec(0, 1, 1, 32'h11111111, 0, 0, 0, 0, 32'h0, 32'h0, "wr_x1");
    add_vec(0, 1, 31, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0, 32'h0, "wr_x31");
    add_vec(0, 0, 0, 32'h0, 1, 1, 1, 31, 32'h11111111, 32'hFFFFFFFF, "rd_x1_x31");
    add_vec(0, 0, 0, 32'h0, 0, 1, 1, 31, 32'h0, 32'hFFFFFFFF, "re1_off");
    // x0 protection
    add_vec(0, 1, 0, 32'hA5A5A5A5, 1, 0, 1, 0, 32'h0, 32'h0, "x0_wr_bypass");
    add_vec(0, 0, 0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, "x0_after");
    // Bypass
    add_vec(0, 1, 7, 32'h00000007, 0, 0, 0, 0, 32'h0, 32'h0, "wr_x7");
    add_vec(0, 1, 7, 32'h77777777, 1, 7, 1, 7, 32'h77777777, 32'h77777777, "bypass_x7");
    add_vec(0, 0, 7, 32'h0, 1, 7, 1, 7, 32'h77777777, 32'h77777777, "x7_after");
    // Bubbles must neither write nor bypass
    add_vec(0, 1, 9, 32'h00000009, 0, 0, 0, 0, 32'h0, 32'h0, "wr_x9");
    add_vec(0, 0, 9, 32'h00000BAD, 1, 9, 1, 9, 32'h9, 32'h9, "stale_no_bypass");
    add_vec(0, 0, 0, 32'h0, 1, 9, 1, 9, 32'h9, 32'h9, "x9_after_bubble");
    // Back-to-back writes to one register
    add_vec(0, 1, 3, 32'h1, 1, 3, 1, 3, 32'h1, 32'h1, "b2b_x3_1");
    add_vec(0, 1, 3, 32'h2, 1, 3, 0, 3, 32'h2, 32'h0, "b2b_x3_2");
    add_vec(0, 1, 3, 32'h3, 1, 3, 1, 3, 32'h3, 32'h3, "b2b_x3_3");
    add_vec(0, 0, 0, 32'h0, 1, 3, 1, 7, 32'h3, 32'h77777777, "x3_final");

    foreach (vecs[i]) begin
      run_cycle(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2,
                vecs[i].exp1, vecs[i].exp2, vecs[i].name, 1'b1);
    end

    // Random traffic against the reference model; collisions are biased up.
    for (int n = 0; n < 600; n++) begin
      logic        r, w, e1, e2;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 3) != 0);
      e1 = ($urandom_range(0, 7) != 0);
      e2 = ($urandom_range(0, 7) != 0);
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      wd = $urandom;
      run_cycle(r, w, wa, wd, e1, a1, e2, a2,
                model_read(r, w, wa, wd, e1, a1),
                model_read(r, w, wa, wd, e2, a2), "rand", 1'b1);
    end

    // Final sweep: every register read back through both ports with no write.
    for (int a = 0; a < 32; a++) begin
      run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a),
                model_read(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a)),
                model_read(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(31 - a)),
                "sweep", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Integer register file (x0..x31) of the RV32I core; the consuming end of the WB write interface driven by the MEM/WB pipeline register (wb_w_enable / wb_w_addr / wb_w_data).
- Sits between the WB stage and the ID stage.
- Provides two read ports to ID, with same-cycle write-to-read bypass so ID never needs a WB forwarding path.
- x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width; must equal the width of `RegBus.
- ADDR_W, 5, register index width; must equal the width of `RegAddrBus.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable, from MEM/WB wb_w_enable.
- waddr  input  ADDR_W  write index, from wb_w_addr.
- wdata  input  DATA_W  write data, from wb_w_data.
- re1  input  1  read-port-1 enable, from ID.
- raddr1  input  ADDR_W  read-port-1 index.
- rdata1  output  DATA_W  read-port-1 data, combinational.
- re2  input  1  read-port-2 enable, from ID.
- raddr2  input  ADDR_W  read-port-2 index.
- rdata2  output  DATA_W  read-port-2 data, combinational.

Behaviour:
- Reset and clocking: one clock. Reset is synchronous and active-high.
- Storage: NUM_REGS x DATA_W array.
- Reset (rst=1 at posedge): every entry 1..31 is cleared to `ZeroWord. Any write presented in the same cycle is discarded.
- Read outputs during reset: while rst=1, rdata1 and rdata2 are `ZeroWord combinationally, independent of all other inputs.
- Write: at posedge with rst=0, we=1 and waddr!=0, reg[waddr] <= wdata. Latency 1 cycle to the array.
  - Writes to x0 are silently dropped.
  - we=0 leaves the array unchanged.
- Read port n (identical logic for n=1,2), evaluated in priority order:
  1. rst=1 -> 0.
  2. re_n=0 -> 0.
  3. raddr_n=0 -> 0.
  4. we=1 and waddr==raddr_n -> wdata (bypass: a value being written this cycle is visible to a read in the same cycle).
  5. Otherwise -> reg[raddr_n].
- No read latency: the read ports are purely combinational from the array and bypass inputs.
- Simultaneous events:
  - Both ports reading the same index as the write -> both return wdata.
  - The bypass applies only with we=1. A stale waddr/wdata with we=0 (e.g. bubble inserted by stall) must not bypass.
- Pipeline bubble: MEM/WB emits we=0, waddr=`NOPRegAddr (0), wdata=0. This must produce no array change and no bypass.
- Reset mid-operation: asserting rst for one cycle at any point clears the state to all zeros. The next cycle behaves as freshly reset.
- No X propagation: array entries are defined after the first reset. Reads of uninitialised entries before the first reset are unspecified, and the bench must not check them.

Decomposition:
- Defines.vh (shared) holds:
  - `RegBus, `RegAddrBus, `RegNum (32), `RegNumLog2 (5).
  - `ZeroWord, `NOPRegAddr.
  - `WriteEnable/`WriteDisable, `ReadEnable/`ReadDisable.
- Sub-module reg_file_rd_port: the priority mux for one read port (rst, re, raddr, we, waddr, wdata, array word -> rdata). reg_file instantiates it twice.
- The write/reset logic stays in reg_file.

Test Plan:
- Reset clear: write x5=0xDEADBEEF; assert rst 1 cycle; read x5 on both ports -> 0x00000000. While rst=1, rdata1=rdata2=0 even with we=1, waddr=5, wdata=0x1234 present; x5 stays 0 after rst drops.
- Basic write/read: write x1=0x11111111, x31=0xFFFFFFFF on consecutive cycles. Then raddr1=1, raddr2=31 with re1=re2=1 -> 0x11111111 / 0xFFFFFFFF. With re1=0 -> rdata1=0.
- x0 protection: we=1, waddr=0, wdata=0xA5A5A5A5. Same-cycle read of x0 -> 0 (no bypass). Next cycle read of x0 -> 0.
- Bypass: x7 holds 0x00000007. Drive we=1, waddr=7, wdata=0x77777777 and raddr1=raddr2=7 in the same cycle -> both 0x77777777 before the clock edge. After the edge, with we=0 -> 0x77777777.
- Bubble: x9=0x9; drive we=0, waddr=9, wdata=0xBAD. Read x9 -> 0x00000009 both same-cycle and after the edge.
- Back-to-back same address: write x3=1, then x3=2, then x3=3 on consecutive cycles while reading x3 every cycle. Each cycle shows the value being written that cycle (1, 2, 3 via bypass); the final array value is 3.
